// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: immediate-extension mode encodings, the shared extension
// function used by decode and by imm_ext_stage, and the skid buffer state type.
package imm_ext_pkg;

   // Widest immediate/operand the shared extension function handles.
   localparam int IMM_MAX_W = 64;

   typedef enum logic [1:0] {
      IMM_ZERO   = 2'b00,
      IMM_SIGN   = 2'b01,
      IMM_UPPER  = 2'b10,
      IMM_BRANCH = 2'b11
   } imm_mode_t;

   // Encoding is {main_valid, skid_valid}, so the valid bits are the state bits.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b10,
      BUF_FULL  = 2'b11
   } buf_state_t;

   // Extends the low in_w bits of imm to out_w bits according to mode.
   // Callers pass their own widths; bits at or above out_w are always zero.
   function automatic logic [IMM_MAX_W-1:0] imm_extend(
      input logic [IMM_MAX_W-1:0] imm,
      input imm_mode_t            mode,
      input int                   in_w     = 16,
      input int                   out_w    = 32,
      input int                   br_shift = 2
   );
      logic [IMM_MAX_W-1:0] mask_in;
      logic [IMM_MAX_W-1:0] mask_out;
      logic [IMM_MAX_W-1:0] raw;
      logic [IMM_MAX_W-1:0] sext;
      logic [IMM_MAX_W-1:0] res;
      logic                 sign_bit;
      mask_in  = (IMM_MAX_W'(1) << in_w) - IMM_MAX_W'(1);
      mask_out = (IMM_MAX_W'(1) << out_w) - IMM_MAX_W'(1);
      raw      = imm & mask_in;
      sign_bit = |(imm & (IMM_MAX_W'(1) << (in_w - 1)));
      sext     = sign_bit ? (raw | ~mask_in) : raw;
      case (mode)
         IMM_ZERO:   res = raw;
         IMM_SIGN:   res = sext;
         IMM_UPPER:  res = raw << (out_w - in_w);
         IMM_BRANCH: res = sext << br_shift;
         default:    res = '0;
      endcase
      return res & mask_out;
   endfunction

endpackage

// File: rtl/skid_buf.sv
// skid_buf: two-entry valid/ready buffer (main + skid register) with a
// registered in_ready and synchronous flush. Strict FIFO order.
module skid_buf
   import imm_ext_pkg::*;
#(
   parameter int W = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_t   state;
   buf_state_t   state_next;
   logic [W-1:0] main_data;
   logic [W-1:0] skid_data;
   logic         push;
   logic         pop;
   logic         load_main;
   logic         load_skid;
   logic         main_from_skid;

   assign out_valid = state[1];
   assign in_ready  = ~state[0];
   assign out_data  = main_data;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // State register; reset leaves the buffer empty and ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BUF_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and register load selects; flush overrides everything.
   always_comb begin
      state_next     = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         BUF_EMPTY: begin
            if (push) begin
               state_next = BUF_ONE;
               load_main  = 1'b1;
            end
         end
         BUF_ONE: begin
            if (push && pop) begin
               load_main = 1'b1;
            end else if (push) begin
               state_next = BUF_FULL;
               load_skid  = 1'b1;
            end else if (pop) begin
               state_next = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (pop) begin
               state_next     = BUF_ONE;
               main_from_skid = 1'b1;
            end
         end
         default: begin
            state_next = BUF_EMPTY;
         end
      endcase
      if (flush) begin
         state_next     = BUF_EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   // Payload registers; main drives the outputs and clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data <= '0;
         skid_data <= '0;
      end else begin
         if (load_main) begin
            main_data <= in_data;
         end else if (main_from_skid) begin
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: extends a raw immediate (zero/sign/upper/branch) on the input
// side and registers the result plus its tag through a two-entry skid buffer.
module imm_ext_stage
   import imm_ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0]       ext_imm;
   logic [OUT_W+TAG_W-1:0] out_payload;

   // Stored entries hold the final extended value, so extend before buffering.
   always_comb begin
      ext_imm = OUT_W'(imm_extend(IMM_MAX_W'(in_imm), imm_mode_t'(in_mode),
                                  IN_W, OUT_W, BR_SHIFT));
   end

   skid_buf #(
      .W(OUT_W + TAG_W)
   ) u_skid_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ext_imm, in_tag}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign out_imm = out_payload[OUT_W+TAG_W-1:TAG_W];
   assign out_tag = out_payload[TAG_W-1:0];

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed and randomized checks of imm_ext_stage against a
// capacity-2 FIFO model with arithmetic immediate extension.
module tb_imm_ext_stage;

   localparam logic [1:0] M_ZERO   = 2'b00;
   localparam logic [1:0] M_SIGN   = 2'b01;
   localparam logic [1:0] M_UPPER  = 2'b10;
   localparam logic [1:0] M_BRANCH = 2'b11;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;

   int total = 0;
   int bad   = 0;
   int seen  = 0;

   logic [31:0] q_imm[$];
   logic [4:0]  q_tag[$];

   imm_ext_stage #(
      .IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Extension from the mode rules using plain integer arithmetic.
   function automatic logic [31:0] ref_ext(input logic [1:0] mode, input logic [15:0] imm);
      int s;
      s = int'($signed(imm));
      case (mode)
         M_ZERO:   return 32'(imm);
         M_SIGN:   return 32'(s);
         M_UPPER:  return 32'(imm) * 32'd65536;
         M_BRANCH: return 32'(s * 4);
         default:  return 32'd0;
      endcase
   endfunction

   task automatic check_value(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Compares handshake and head-of-queue data against the model.
   task automatic check_output(input string name);
      check_value({name, "_in_ready"}, 64'(in_ready), 64'(q_imm.size() < 2));
      check_value({name, "_out_valid"}, 64'(out_valid), 64'(q_imm.size() > 0));
      if (q_imm.size() > 0) begin
         check_value({name, "_out_imm"}, 64'(out_imm), 64'(q_imm[0]));
         check_value({name, "_out_tag"}, 64'(out_tag), 64'(q_tag[0]));
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] mode, input logic [15:0] imm, input logic [4:0] tag);
      in_valid = 1'b1;
      in_mode  = mode;
      in_imm   = imm;
      in_tag   = tag;
   endtask

   // One clock: update the FIFO model from pre-edge inputs, then check.
   task automatic step(input string name);
      bit          do_pop;
      bit          do_push;
      bit          do_flush;
      logic [31:0] e_imm;
      logic [4:0]  e_tag;
      do_pop   = (q_imm.size() > 0) && (out_ready === 1'b1);
      do_push  = (in_valid === 1'b1) && (q_imm.size() < 2);
      do_flush = (flush === 1'b1);
      e_imm    = ref_ext(in_mode, in_imm);
      e_tag    = in_tag;
      @(posedge clk);
      if (do_flush) begin
         q_imm.delete();
         q_tag.delete();
      end else begin
         if (do_pop) begin
            void'(q_imm.pop_front());
            void'(q_tag.pop_front());
         end
         if (do_push) begin
            q_imm.push_back(e_imm);
            q_tag.push_back(e_tag);
         end
      end
      #1;
      check_output(name);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_imm    = '0;
      in_mode   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      #12;
      check_value("rst_out_valid", 64'(out_valid), 64'd0);
      check_value("rst_out_imm", 64'(out_imm), 64'd0);
      check_value("rst_out_tag", 64'(out_tag), 64'd0);
      check_value("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      apply_stimulus(M_SIGN, 16'h8001, 5'd1);
      step("sign");
      check_value("sign_const", 64'(out_imm), 64'hFFFF8001);
      apply_stimulus(M_ZERO, 16'h8001, 5'd2);
      step("zero");
      check_value("zero_const", 64'(out_imm), 64'h00008001);
      apply_stimulus(M_UPPER, 16'h1234, 5'd3);
      step("upper");
      check_value("upper_const", 64'(out_imm), 64'h12340000);
      apply_stimulus(M_BRANCH, 16'hFFFF, 5'd4);
      step("branch_neg");
      check_value("branch_neg_const", 64'(out_imm), 64'hFFFFFFFC);
      apply_stimulus(M_BRANCH, 16'h0010, 5'd5);
      step("branch_pos");
      check_value("branch_pos_const", 64'(out_imm), 64'h00000040);
      in_valid = 1'b0;
      step("drain");
      check_value("drain_empty", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      apply_stimulus(M_SIGN, 16'($urandom), 5'd1);
      step("bp1");
      apply_stimulus(M_ZERO, 16'($urandom), 5'd2);
      step("bp2");
      check_value("bp_full_ready", 64'(in_ready), 64'd0);
      apply_stimulus(M_UPPER, 16'($urandom), 5'd3);
      step("bp3");
      check_value("bp_hold_ready", 64'(in_ready), 64'd0);
      check_value("bp_hold_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      step("rel1");
      check_value("rel1_tag", 64'(out_tag), 64'd2);
      step("rel2");
      check_value("rel2_tag", 64'(out_tag), 64'd3);
      in_valid = 1'b0;
      step("rel3");
      check_value("rel3_empty", 64'(out_valid), 64'd0);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(2'($urandom), 16'($urandom), 5'(i + 8));
         step("stream");
         if (out_valid === 1'b1) seen++;
      end
      in_valid = 1'b0;
      step("stream_end");
      check_value("stream_count", 64'(seen), 64'd8);

      out_ready = 1'b0;
      apply_stimulus(M_SIGN, 16'($urandom), 5'd10);
      step("fl_fill1");
      apply_stimulus(M_ZERO, 16'($urandom), 5'd11);
      step("fl_fill2");
      apply_stimulus(M_BRANCH, 16'h7777, 5'd12);
      flush = 1'b1;
      step("flush");
      check_value("flush_out_valid", 64'(out_valid), 64'd0);
      check_value("flush_in_ready", 64'(in_ready), 64'd1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("post_flush");
      end

      out_ready = 1'b0;
      apply_stimulus(M_SIGN, 16'($urandom), 5'd20);
      step("ar_fill1");
      apply_stimulus(M_UPPER, 16'($urandom), 5'd21);
      step("ar_fill2");
      in_valid = 1'b0;
      #3;
      rst   = 1'b1;
      flush = 1'b1;
      #1;
      check_value("arst_out_valid", 64'(out_valid), 64'd0);
      check_value("arst_out_imm", 64'(out_imm), 64'd0);
      check_value("arst_out_tag", 64'(out_tag), 64'd0);
      check_value("arst_in_ready", 64'(in_ready), 64'd1);
      q_imm.delete();
      q_tag.delete();
      #1;
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      apply_stimulus(M_BRANCH, 16'h0010, 5'd22);
      step("post_rst");
      check_value("post_rst_tag", 64'(out_tag), 64'd22);
      check_value("post_rst_imm", 64'(out_imm), 64'h00000040);

      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_mode   = 2'($urandom);
         in_imm    = 16'($urandom);
         in_tag    = 5'($urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
